// File: rtl/uart_pkg.sv
// Shared UART receive-side sizing, parity-mode constants and frame-length helper.
package uart_pkg;

  localparam int unsigned CNT_W    = 19;
  localparam int unsigned MAX_BITS = 11;
  localparam int unsigned BC_W     = $clog2(MAX_BITS + 1);

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Captured receive byte plus its error flags.
  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_frame_t;

  // Bit-time count per frame including start and stop bits.
  function automatic logic [BC_W-1:0] nbits(input logic eight, input logic pen);
    return BC_W'(9) + BC_W'(eight) + BC_W'(pen);
  endfunction

endpackage

// File: rtl/bit_time_counter.sv
// Bit-time counter: half-bit timing during the start bit, full-bit timing afterwards.
module bit_time_counter #(
  parameter int unsigned CNT_W = uart_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] k,
  input  logic             DoIt,
  input  logic             Start,
  output logic             Btu
);

  logic [CNT_W-1:0] btc_q;
  logic [CNT_W-1:0] btc_d;
  logic [CNT_W-1:0] target;

  always_comb begin
    target = Start ? ((k >> 1) - CNT_W'(1)) : (k - CNT_W'(1));
    Btu    = DoIt && (btc_q == target);
    btc_d  = (!DoIt || Btu) ? '0 : btc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btc_q <= '0;
    end else begin
      btc_q <= btc_d;
    end
  end

endmodule

// File: rtl/rx_datapath.sv
// UART receive datapath: bit counting, serial shift, frame capture and status flags.
module rx_datapath #(
  parameter int unsigned CNT_W    = uart_pkg::CNT_W,
  parameter int unsigned MAX_BITS = uart_pkg::MAX_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Rx,
  input  logic [CNT_W-1:0] k,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             DoIt,
  input  logic             Start,
  input  logic             read_clr,
  output logic             Btu,
  output logic             Done,
  output logic [7:0]       rx_data,
  output logic             rx_rdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf
);
  import uart_pkg::*;

  localparam int unsigned SR_W  = MAX_BITS - 1;
  localparam int unsigned BIT_W = $clog2(MAX_BITS + 1);

  logic [BIT_W-1:0] bc_q, bc_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             done_q, done_d;
  rx_frame_t        frm_q, frm_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;

  logic [BIT_W-1:0] n_bits;
  logic [SR_W-1:0]  frame;
  logic [7:0]       data_bits;
  logic             par_bit;
  logic             stop_bit;
  logic             cap;

  bit_time_counter #(.CNT_W(CNT_W)) u_btc (
    .clk   (clk),
    .reset (reset),
    .k     (k),
    .DoIt  (DoIt),
    .Start (Start),
    .Btu   (Btu)
  );

  // Right-align the received bits so data always starts at index 0.
  always_comb begin
    n_bits    = BIT_W'(nbits(eight, pen));
    frame     = sr_q >> (BIT_W'(MAX_BITS) - n_bits);
    data_bits = eight ? frame[7:0] : {1'b0, frame[6:0]};
    par_bit   = frame[BIT_W'(7) + BIT_W'(eight)];
    stop_bit  = frame[n_bits - BIT_W'(2)];
    Done      = DoIt && (bc_q == n_bits);
    cap       = Done && !done_q;
  end

  always_comb begin
    bc_d   = bc_q;
    sr_d   = sr_q;
    done_d = Done;
    frm_d  = frm_q;
    rdy_d  = cap | (rdy_q & ~read_clr);
    ovf_d  = read_clr ? 1'b0 : (ovf_q | (cap & rdy_q));

    if (!DoIt) begin
      bc_d = '0;
    end else if (Btu) begin
      bc_d = bc_q + BIT_W'(1);
    end

    // The start-bit sample is not part of the frame.
    if (Btu && !Start) begin
      sr_d = {Rx, sr_q[SR_W-1:1]};
    end

    if (cap) begin
      frm_d.data = data_bits;
      frm_d.perr = pen & (^data_bits ^ par_bit ^ ohel);
      frm_d.ferr = ~stop_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bc_q   <= '0;
      sr_q   <= '0;
      done_q <= 1'b0;
      frm_q  <= '0;
      rdy_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bc_q   <= bc_d;
      sr_q   <= sr_d;
      done_q <= done_d;
      frm_q  <= frm_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rx_data = frm_q.data;
  assign perr    = frm_q.perr;
  assign ferr    = frm_q.ferr;
  assign rx_rdy  = rdy_q;
  assign ovf     = ovf_q;

endmodule
